btn_counter8: RTL and testbench
===============================

// Module: btn_counter8
// PURPOSE
//  Upstream value source for the two-digit 7-segment display driver.
//  - Debounces three push-buttons (up, down, load) and keeps an 8-bit count.
//  - Drives val[3:0] as the right digit and val[7:4] as the left digit.
//  - Replaces raw slide switches as the display's nibble source; sw[7:0] remains as load data.
// PARAMETERS
//  DB_CYCLES  250000  consecutive stable clk cycles before a button change is accepted (>=2)
//  DB_W       18      debounce counter width; must satisfy 2**DB_W > DB_CYCLES
// PORTS
//  clk     in   1  system clock, single domain
//  clr     in   1  synchronous active-high reset
//  btn_up  in   1  raw async push-button, increment on press
//  btn_dn  in   1  raw async push-button, decrement on press
//  btn_ld  in   1  raw async push-button, load sw on press
//  sw      in   8  load data; sampled on the cycle the load is applied
//  val     out  8  current count; [7:4] left digit, [3:0] right digit
//  evt     out  1  one-cycle pulse on the cycle val is updated by a button
//  wrap    out  1  one-cycle pulse when up/down crosses the max<->0 boundary
// BEHAVIOUR
//  - Reset: all state synchronous on clr=1 at posedge clk.
//    - Outputs: val=8'h00, evt=0, wrap=0.
//    - Internal: synchronizers, debounce counters and stable levels all 0.
//  - Synchronizer: per button, 2-FF chain; s2 = raw delayed 2 edges.
//  - Debounce, per button, independent:
//    - If s2==stable: cnt<=0.
//    - Else if cnt==DB_CYCLES-1: stable<=s2, cnt<=0.
//    - Else: cnt<=cnt+1.
//    - Any glitch shorter than DB_CYCLES consecutive cycles is rejected; the count restarts.
//  - Press event: stable rises (stable=1, stable_d=0); registered into ev_* for one cycle.
//    - Release generates no event.
//    - Holding a button gives exactly one event.
//  - Latency: raw held high from edge 1 -> val/evt update at edge DB_CYCLES+4, exactly.
//  - Update, in the cycle after ev_* is set; priority order:
//    1. clr: reset as above.
//    2. ev_ld: val<=sw (BCD clamp below); wrap=0.
//    3. ev_up & ev_dn together: no change, evt=0.
//    4. ev_up: val<=val+1.
//    5. ev_dn: val<=val-1.
//    - evt=1 whenever val is written, even if the value is unchanged (load of same value).
//  - Wrap, binary: FF+1 -> 00 and 00-1 -> FF, each with wrap=1 for one cycle.
//  - Reset mid-operation: clr during a debounce discards partial counts.
//    - A button still held after clr produces a fresh event after full debounce.
//  - No FSM beyond the per-button debounce/edge logic; no combinational path from inputs to outputs.
// CONFIGURATION
//  BTN_BCD_EN defined:
//    - val counts decimal 00..99 in BCD.
//    - up: right digit 9->0 carries into left; 99+1 -> 00, wrap=1.
//    - down: 00-1 -> 99, wrap=1.
//    - load: each sw nibble >9 is clamped to 9 (e.g. sw=8'hA3 -> val=8'h93).
//  BTN_BCD_EN undefined: plain 8-bit binary as above; load is unmodified.
// TESTING  (DB_CYCLES=4 for simulation)
//  1. Reset: clr=1 for 2 cycles with buttons high.
//     -> val=00, evt=0, wrap=0.
//     -> After release, one event at edge 8: val=01.
//  2. Debounce: btn_up pulses of 3 cycles, then held 10 cycles.
//     -> Pulses give no change.
//     -> Hold gives exactly one evt; val 00->01 at edge DB_CYCLES+4 from hold start.
//  3. Load then up (binary): sw=8'hFF, press ld -> val=FF.
//     -> Then press up -> val=00, wrap=1 for 1 cycle, evt=1.
//  4. Down from zero (binary): val=00, press dn -> val=FF, wrap=1.
//     -> With BTN_BCD_EN: val=99, wrap=1.
//  5. Simultaneous up+dn rising on the same edge -> no change, evt=0.
//     -> With ld also pressed: val=sw.
//  6. BCD (BTN_BCD_EN): load sw=8'h39, press up -> val=40.
//     -> Load sw=8'hAF -> val=99; press up -> val=00, wrap=1.

Source files
------------

// File: rtl/btn_counter8_if.sv
// Button, load-data and display-value signals between btn_counter8 and its environment.
interface btn_counter8_if;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_ld;
    logic [7:0] sw;
    logic [7:0] val;
    logic       evt;
    logic       wrap;

    modport master (output btn_up, btn_dn, btn_ld, sw, input val, evt, wrap);
    modport slave  (input btn_up, btn_dn, btn_ld, sw, output val, evt, wrap);
endinterface

// File: rtl/btn_counter8.sv
// btn_counter8: debounced up/down/load push-buttons driving the 8-bit display value.
// Define BTN_BCD_EN for a decimal 00..99 BCD counter with per-nibble load clamping.
module btn_counter8 #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned DB_W      = 18
) (
    input logic           clk,
    input logic           clr,
    btn_counter8_if.slave bus
);
    localparam int unsigned     NB       = 3;
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [NB-1:0]   raw, s1, s2, stable, stable_d, ev;
    logic [DB_W-1:0] cnt [NB];
    logic [7:0]      val_q, val_nxt;
    logic            evt_q, wrap_q, upd, wrap_nxt;

`ifdef BTN_BCD_EN
    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'h9) ? 4'h9 : n;
    endfunction

    function automatic logic [7:0] load_val(input logic [7:0] v);
        return {clamp9(v[7:4]), clamp9(v[3:0])};
    endfunction

    // Returns {wrap, next value}
    function automatic logic [8:0] step_up(input logic [7:0] v);
        if (v == 8'h99)       return {1'b1, 8'h00};
        if (v[3:0] == 4'h9)   return {1'b0, v[7:4] + 4'h1, 4'h0};
        return {1'b0, v + 8'h01};
    endfunction

    function automatic logic [8:0] step_dn(input logic [7:0] v);
        if (v == 8'h00)       return {1'b1, 8'h99};
        if (v[3:0] == 4'h0)   return {1'b0, v[7:4] - 4'h1, 4'h9};
        return {1'b0, v - 8'h01};
    endfunction
`else
    function automatic logic [7:0] load_val(input logic [7:0] v);
        return v;
    endfunction

    function automatic logic [8:0] step_up(input logic [7:0] v);
        return {v == 8'hFF, v + 8'h01};
    endfunction

    function automatic logic [8:0] step_dn(input logic [7:0] v);
        return {v == 8'h00, v - 8'h01};
    endfunction
`endif

    // bit 0 = up, bit 1 = down, bit 2 = load
    assign raw = {bus.btn_ld, bus.btn_dn, bus.btn_up};

    always_ff @(posedge clk) begin
        if (clr) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            ev       <= '0;
            for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            ev       <= stable & ~stable_d;
            for (int unsigned i = 0; i < NB; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Load wins; up and down arriving together cancel out.
    always_comb begin
        val_nxt  = val_q;
        upd      = 1'b0;
        wrap_nxt = 1'b0;
        if (ev[2]) begin
            upd     = 1'b1;
            val_nxt = load_val(bus.sw);
        end else if (ev[0] ^ ev[1]) begin
            upd = 1'b1;
            if (ev[0]) {wrap_nxt, val_nxt} = step_up(val_q);
            else       {wrap_nxt, val_nxt} = step_dn(val_q);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            val_q  <= '0;
            evt_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            if (upd) val_q <= val_nxt;
            evt_q  <= upd;
            wrap_q <= wrap_nxt;
        end
    end

    assign bus.val  = val_q;
    assign bus.evt  = evt_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_btn_counter8.sv
// Randomised and directed bench for btn_counter8 against a run-length/queue reference model.
module tb_btn_counter8;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   failures = 0;

    btn_counter8_if bus();

    btn_counter8 #(.DB_CYCLES(DB), .DB_W(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef BTN_BCD_EN
    localparam int         MOD        = 100;
    localparam logic [7:0] EXP_MAX    = 8'h99;
    localparam logic [7:0] EXP_39UP   = 8'h40;
    localparam logic [7:0] EXP_AF     = 8'h99;
    localparam logic [7:0] EXP_AFUP   = 8'h00;
    localparam int         EXP_AFWRAP = 1;

    function automatic int to_num(input logic [7:0] v);
        return 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] from_num(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] loaded(input logic [7:0] s);
        int hi;
        int lo;
        hi = (int'(s[7:4]) > 9) ? 9 : int'(s[7:4]);
        lo = (int'(s[3:0]) > 9) ? 9 : int'(s[3:0]);
        return from_num(10 * hi + lo);
    endfunction
`else
    localparam int         MOD        = 256;
    localparam logic [7:0] EXP_MAX    = 8'hFF;
    localparam logic [7:0] EXP_39UP   = 8'h3A;
    localparam logic [7:0] EXP_AF     = 8'hAF;
    localparam logic [7:0] EXP_AFUP   = 8'hB0;
    localparam int         EXP_AFWRAP = 0;

    function automatic int to_num(input logic [7:0] v);
        return int'(v);
    endfunction

    function automatic logic [7:0] from_num(input int n);
        return 8'(n);
    endfunction

    function automatic logic [7:0] loaded(input logic [7:0] s);
        return s;
    endfunction
`endif

    // Reference model: raw samples reach the debouncer two edges late; a level is
    // accepted after DB consecutive differing samples; a press shows on val two edges later.
    logic [7:0] m_val  = '0;
    logic       m_evt  = 1'b0;
    logic       m_wrap = 1'b0;
    logic [2:0] rawq[$] = '{3'b000, 3'b000};
    logic [2:0] evq[$]  = '{3'b000, 3'b000};
    logic [2:0] m_lvl   = '0;
    int         run[3]  = '{0, 0, 0};
    logic [2:0] m_raw, m_del, m_acc, m_fire;

    always @(posedge clk) begin
        m_raw = {bus.btn_ld, bus.btn_dn, bus.btn_up};
        if (clr) begin
            rawq   = '{3'b000, 3'b000};
            evq    = '{3'b000, 3'b000};
            run    = '{0, 0, 0};
            m_lvl  = '0;
            m_val  = '0;
            m_evt  = 1'b0;
            m_wrap = 1'b0;
        end else begin
            m_del = rawq.pop_front();
            rawq.push_back(m_raw);
            m_fire = evq.pop_front();
            m_acc  = '0;
            for (int b = 0; b < 3; b++) begin
                if (m_del[b] != m_lvl[b]) begin
                    run[b]++;
                    if (run[b] == int'(DB)) begin
                        m_lvl[b] = m_del[b];
                        m_acc[b] = m_del[b];
                        run[b]   = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            evq.push_back(m_acc);
            m_evt  = 1'b0;
            m_wrap = 1'b0;
            if (m_fire[2]) begin
                m_val = loaded(bus.sw);
                m_evt = 1'b1;
            end else if (m_fire[0] && !m_fire[1]) begin
                m_wrap = (to_num(m_val) == MOD - 1);
                m_val  = from_num((to_num(m_val) + 1) % MOD);
                m_evt  = 1'b1;
            end else if (m_fire[1] && !m_fire[0]) begin
                m_wrap = (to_num(m_val) == 0);
                m_val  = from_num((to_num(m_val) + MOD - 1) % MOD);
                m_evt  = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clr();
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.btn_ld = 1'b0;
        clr = 1'b1;
        repeat (2) tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int evts = 0;
        bus.btn_up = 1'b1;
        bus.btn_dn = 1'b0;
        bus.btn_ld = 1'b0;
        bus.sw = 8'h5A;
        clr = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.val, bus.evt, bus.wrap} !== 10'h000) begin
            failures++;
            $display("FAIL reset_state val=%h evt=%b wrap=%b, expected 00/0/0", bus.val, bus.evt, bus.wrap);
        end
        clr = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            if (e == 13) bus.btn_up = 1'b0;
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL reset_model edge=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", e, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
            evts += int'(bus.evt);
            if (e == int'(DB) + 4) begin
                checks++;
                if (bus.val !== 8'h01 || bus.evt !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_first_event val=%h evt=%b, expected 01/1", bus.val, bus.evt);
                end
            end
        end
        checks++;
        if (evts != 1) begin
            failures++;
            $display("FAIL reset_event_count got=%0d expected=1", evts);
        end
    endtask

    task automatic test_debounce();
        int evts = 0;
        do_clr();
        for (int c = 0; c < 46; c++) begin
            bus.btn_up = (c < 18) ? ((c % 6) < 3) : (c < 28);
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL debounce_model c=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", c, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
            evts += int'(bus.evt);
            if (c == 17 + int'(DB) + 3) begin
                checks++;
                if (bus.val !== 8'h00 || bus.evt !== 1'b0) begin
                    failures++;
                    $display("FAIL debounce_early val=%h evt=%b, expected 00/0", bus.val, bus.evt);
                end
            end
            if (c == 17 + int'(DB) + 4) begin
                checks++;
                if (bus.val !== 8'h01 || bus.evt !== 1'b1) begin
                    failures++;
                    $display("FAIL debounce_latency val=%h evt=%b, expected 01/1", bus.val, bus.evt);
                end
            end
        end
        checks++;
        if (evts != 1) begin
            failures++;
            $display("FAIL debounce_event_count got=%0d expected=1", evts);
        end
    endtask

    task automatic test_load_wrap();
        int wraps = 0;
        int evts = 0;
        do_clr();
        bus.sw = 8'hFF;
        for (int c = 0; c < 40; c++) begin
            bus.btn_ld = (c < 10);
            bus.btn_up = (c >= 20 && c < 30);
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL loadwrap_model c=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", c, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
            if (c == 19) begin
                checks++;
                if (bus.val !== EXP_MAX) begin
                    failures++;
                    $display("FAIL load_max val=%h expected=%h", bus.val, EXP_MAX);
                end
            end
            if (c >= 20) begin
                wraps += int'(bus.wrap);
                evts  += int'(bus.evt);
            end
        end
        checks++;
        if (bus.val !== 8'h00 || wraps != 1 || evts != 1) begin
            failures++;
            $display("FAIL up_wrap val=%h wraps=%0d evts=%0d, expected 00/1/1", bus.val, wraps, evts);
        end
    endtask

    task automatic test_down_zero();
        int wraps = 0;
        do_clr();
        for (int c = 0; c < 20; c++) begin
            bus.btn_dn = (c < 10);
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL down_model c=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", c, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
            wraps += int'(bus.wrap);
        end
        checks++;
        if (bus.val !== EXP_MAX || wraps != 1) begin
            failures++;
            $display("FAIL down_wrap val=%h wraps=%0d, expected %h/1", bus.val, wraps, EXP_MAX);
        end
    endtask

    task automatic test_simultaneous();
        int         evts = 0;
        logic [7:0] s;
        do_clr();
        s = 8'($urandom);
        bus.sw = s;
        for (int c = 0; c < 60; c++) begin
            bus.btn_up = (c < 10) || (c >= 20 && c < 30);
            bus.btn_dn = (c < 10) || (c >= 20 && c < 30);
            bus.btn_ld = (c >= 20 && c < 30) || (c >= 40 && c < 50);
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL simul_model c=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", c, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
            evts += int'(bus.evt);
            if (c == 19 || c == 39 || c == 59) begin
                checks++;
                if (bus.val !== ((c == 19) ? 8'h00 : loaded(s)) || evts != ((c == 19) ? 0 : 1)) begin
                    failures++;
                    $display("FAIL simul_phase c=%0d val=%h evts=%0d sw=%h", c, bus.val, evts, s);
                end
                evts = 0;
            end
        end
    endtask

    task automatic test_bcd();
        int wraps = 0;
        do_clr();
        bus.sw = 8'h39;
        for (int c = 0; c < 80; c++) begin
            if (c == 40) bus.sw = 8'hAF;
            bus.btn_ld = (c < 10) || (c >= 40 && c < 50);
            bus.btn_up = (c >= 20 && c < 30) || (c >= 60 && c < 70);
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL bcd_model c=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", c, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
            if (c >= 60) wraps += int'(bus.wrap);
            if (c == 39 || c == 59 || c == 79) begin
                checks++;
                if (bus.val !== ((c == 39) ? EXP_39UP : (c == 59) ? EXP_AF : EXP_AFUP)) begin
                    failures++;
                    $display("FAIL bcd_value c=%0d val=%h", c, bus.val);
                end
            end
        end
        checks++;
        if (wraps != EXP_AFWRAP) begin
            failures++;
            $display("FAIL bcd_wrap got=%0d expected=%0d", wraps, EXP_AFWRAP);
        end
    endtask

    task automatic test_random();
        logic [2:0] lvl = '0;
        int         hold[3] = '{0, 0, 0};
        do_clr();
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = ($urandom_range(0, 2) == 0);
                    hold[b] = int'($urandom_range(1, 12));
                end
                hold[b]--;
            end
            bus.btn_up = lvl[0];
            bus.btn_dn = lvl[1];
            bus.btn_ld = (lvl[2] && $urandom_range(0, 3) != 0) ? lvl[2] : 1'b0;
            bus.sw     = 8'($urandom);
            clr        = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({bus.val, bus.evt, bus.wrap} !== {m_val, m_evt, m_wrap}) begin
                failures++;
                $display("FAIL random_model c=%0d val=%h evt=%b wrap=%b, expected %h/%b/%b", c, bus.val, bus.evt, bus.wrap, m_val, m_evt, m_wrap);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.btn_ld = 1'b0;
        bus.sw     = 8'h00;
        test_reset();
        test_debounce();
        test_load_wrap();
        test_down_zero();
        test_simultaneous();
        test_bcd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
